// File: rtl/decode_skid_stage.sv
// decode_skid_stage
//   Decode-stage pipeline buffer between instruction fetch and execute.
//   Instructions arrive with their PC over a valid/ready handshake. Each one is
//   decoded into its fields as it is captured. Up to two decoded entries are held:
//   a head entry that drives the outputs, and a skid entry behind it. Because of
//   the skid entry, in_ready can come straight from a flop.
//
// Parameters
//   DATA_W  instruction / PC / extended-immediate width
//   IMM_W   immediate field width, taken from instr[IMM_W-1:0]
//
// Ports
//   clock, reset       rising-edge clock, asynchronous active-high reset
//   flush              synchronous discard of all held entries
//   in_valid/in_ready  fetch-side handshake; in_ready depends only on state
//   in_instr, in_pc    raw instruction and its PC
//   out_valid/out_ready execute-side handshake for the head entry
//   out_pc             PC of the head entry
//   out_opcode..aluop  5-bit instruction fields [31:27] .. [6:2]
//   out_imm_ext        sign-extended immediate
//   out_target         zero-extended instr[26:0] jump target
//   out_is_itype       opcode is one of the immediate-format opcodes
module decode_skid_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMM_W  = 17
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [4:0]        out_opcode,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs,
  output logic [4:0]        out_rt,
  output logic [4:0]        out_shamt,
  output logic [4:0]        out_aluop,
  output logic [DATA_W-1:0] out_imm_ext,
  output logic [DATA_W-1:0] out_target,
  output logic              out_is_itype
);

  // One decoded entry, as held in either the head or the skid register.
  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [4:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        shamt;
    logic [4:0]        aluop;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] target;
    logic              is_itype;
  } entry_t;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e state_q, state_d;
  entry_t head_q, skid_q;
  entry_t in_dec;

  logic in_ready_q, out_valid_q;
  logic push, pop;
  logic head_load_in, head_load_skid, skid_load;

  // instr[1:0] carries no field.
  logic unused_instr_bits;
  assign unused_instr_bits = ^in_instr[1:0];

  // Decode of the incoming instruction, captured into head or skid on push.
  always_comb begin
    in_dec          = '0;
    in_dec.pc       = in_pc;
    in_dec.opcode   = in_instr[31:27];
    in_dec.rd       = in_instr[26:22];
    in_dec.rs       = in_instr[21:17];
    in_dec.rt       = in_instr[16:12];
    in_dec.shamt    = in_instr[11:7];
    in_dec.aluop    = in_instr[6:2];
    in_dec.imm_ext  = {{(DATA_W-IMM_W){in_instr[IMM_W-1]}}, in_instr[IMM_W-1:0]};
    in_dec.target   = {{(DATA_W-27){1'b0}}, in_instr[26:0]};
    in_dec.is_itype = in_instr[31:27] inside {5'b00101, 5'b00111, 5'b01000,
                                              5'b00010, 5'b00110};
  end

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  // Next state and register load enables. Flush overrides everything; the data
  // registers are left alone since out_valid masks them.
  always_comb begin
    state_d        = state_q;
    head_load_in   = 1'b0;
    head_load_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (push) begin
            state_d      = StOne;
            head_load_in = 1'b1;
          end
        end
        StOne: begin
          if (push && pop) begin
            // Head leaves and the new entry takes its place.
            head_load_in = 1'b1;
          end else if (push) begin
            state_d   = StTwo;
            skid_load = 1'b1;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            state_d        = StOne;
            head_load_skid = 1'b1;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StEmpty;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head_q      <= '0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_d;
      // Handshake flags are precomputed from the next state so both ports are
      // driven directly by flops.
      in_ready_q  <= (state_d != StTwo);
      out_valid_q <= (state_d != StEmpty);
      if (head_load_in) begin
        head_q <= in_dec;
      end else if (head_load_skid) begin
        head_q <= skid_q;
      end
      if (skid_load) begin
        skid_q <= in_dec;
      end
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_pc       = head_q.pc;
  assign out_opcode   = head_q.opcode;
  assign out_rd       = head_q.rd;
  assign out_rs       = head_q.rs;
  assign out_rt       = head_q.rt;
  assign out_shamt    = head_q.shamt;
  assign out_aluop    = head_q.aluop;
  assign out_imm_ext  = head_q.imm_ext;
  assign out_target   = head_q.target;
  assign out_is_itype = head_q.is_itype;

endmodule
